// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the sweeper and its environment (requester + device under characterisation).
// slave is the sweeper's view; master is the environment's view.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [7:0] expected_code;
  logic [2:0] stim;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic [7:0] table_code;
  logic       match;
  logic [7:0] mismatch_mask;

  modport master (
    output start, abort, expected_code, dut_out,
    input  stim, busy, done, table_code, match, mismatch_mask
  );

  modport slave (
    input  start, abort, expected_code, dut_out,
    output stim, busy, done, table_code, match, mismatch_mask
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input logic block through rows 000..111, samples its output after a settle
// window, builds the 8-bit truth-table code and compares it with an expected code.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave bus
);

  typedef enum logic {IDLE, DRIVE} state_e;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       exp_q, exp_d;
  logic [2:0]       stim_q, stim_d;
  logic             done_q, done_d;
  logic [7:0]       code_q, code_d;
  logic             match_q, match_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       acc_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      exp_q   <= '0;
      stim_q  <= '0;
      done_q  <= 1'b0;
      code_q  <= '0;
      match_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      exp_q   <= exp_d;
      stim_q  <= stim_d;
      done_q  <= done_d;
      code_q  <= code_d;
      match_q <= match_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    exp_d   = exp_q;
    stim_d  = stim_q;
    done_d  = 1'b0;
    code_d  = code_q;
    match_d = match_q;
    mask_d  = mask_q;

    // Row k lands in bit (7-k) so the code reads like the library module names.
    acc_sample                = acc_q;
    acc_sample[3'd7 - idx_q]  = bus.dut_out;

    case (state_q)
      IDLE: begin
        stim_d = '0;
        if (bus.start && !bus.abort) begin
          exp_d   = bus.expected_code;
          idx_d   = '0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_d = IDLE;
          stim_d  = '0;
        end else if (cnt_q != SETTLE_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          acc_d = acc_sample;
          if (idx_q != 3'd7) begin
            idx_d  = idx_q + 3'd1;
            stim_d = idx_q + 3'd1;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            stim_d  = '0;
            done_d  = 1'b1;
            code_d  = acc_sample;
            mask_d  = acc_sample ^ exp_q;
            match_d = (acc_sample == exp_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stim          = stim_q;
  assign bus.busy          = (state_q == DRIVE);
  assign bus.done          = done_q;
  assign bus.table_code    = code_q;
  assign bus.match         = match_q;
  assign bus.mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboarded bench: two sweepers (settle 4 and settle 0) characterise behavioural
// 3-input gates whose truth table is chosen per sweep.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_sweeper_if if4();
  truth_table_sweeper_if if0();

  // Device under characterisation: output for row k is bit (7-k) of its function code.
  logic [7:0] gate4 = 8'h00;
  logic [7:0] gate0 = 8'h00;
  assign if4.dut_out = gate4[3'd7 - if4.stim];
  assign if0.dut_out = gate0[3'd7 - if0.stim];

  truth_table_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(0), .CNT_W(8)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  typedef struct {
    logic [7:0] code;
    logic       m;
    logic [7:0] mask;
    int         due;
  } exp_t;

  exp_t q4[$];
  exp_t q0[$];
  exp_t e4, e0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic active4 = 1'b0, active0 = 1'b0;
  int   st4 = 0, st0 = 0;
  logic [7:0] last4 = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: per-row comparison of the gate's response against the expected table.
  function automatic exp_t model(input logic [7:0] g, input logic [7:0] e, input int due);
    exp_t r;
    int diffs;
    r.code = '0;
    r.mask = '0;
    diffs  = 0;
    for (int k = 0; k < 8; k++) begin
      r.code[7-k] = g[7-k];
      if (g[7-k] != e[7-k]) begin
        r.mask[7-k] = 1'b1;
        diffs++;
      end
    end
    r.m   = (diffs == 0);
    r.due = due;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitors sample on the falling edge, away from the launching edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (active4 && (cyc - st4) < 40) begin
        chk("busy4", int'(if4.busy), 1);
        chk("stim4", int'(if4.stim), (cyc - st4) / 5);
      end
      if (if4.done) begin
        if (q4.size() == 0) chk("spurious_done4", 1, 0);
        else begin
          e4 = q4.pop_front();
          chk("code4", int'(if4.table_code), int'(e4.code));
          chk("match4", int'(if4.match), int'(e4.m));
          chk("mask4", int'(if4.mismatch_mask), int'(e4.mask));
          chk("latency4", cyc, e4.due);
          $display("sweep S=4 code=%02h match=%0b mask=%02h cycle=%0d",
                   if4.table_code, if4.match, if4.mismatch_mask, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (active0 && (cyc - st0) < 8) begin
        chk("busy0", int'(if0.busy), 1);
        chk("stim0", int'(if0.stim), cyc - st0);
      end
      if (if0.done) begin
        if (q0.size() == 0) chk("spurious_done0", 1, 0);
        else begin
          e0 = q0.pop_front();
          chk("code0", int'(if0.table_code), int'(e0.code));
          chk("match0", int'(if0.match), int'(e0.m));
          chk("mask0", int'(if0.mismatch_mask), int'(e0.mask));
          chk("latency0", cyc, e0.due);
          $display("sweep S=0 code=%02h match=%0b mask=%02h cycle=%0d",
                   if0.table_code, if0.match, if0.mismatch_mask, cyc);
        end
      end
    end
  end

  task automatic drain4();
    for (int i = 0; i < 100 && q4.size() != 0; i++) tick(1);
    if (q4.size() != 0) begin
      chk("timeout4", q4.size(), 0);
      q4.delete();
    end
    active4 = 1'b0;
  endtask

  task automatic drain0();
    for (int i = 0; i < 40 && q0.size() != 0; i++) tick(1);
    if (q0.size() != 0) begin
      chk("timeout0", q0.size(), 0);
      q0.delete();
    end
    active0 = 1'b0;
  endtask

  // One settle-4 sweep; optional abort edge and optional ignored re-start edge (0 = none).
  task automatic sweep4(input logic [7:0] g, input logic [7:0] e,
                        input int abort_at, input int restart_at);
    int n;
    gate4 = g;
    if4.expected_code = e;
    if4.start = 1'b1;
    tick(1);
    if4.start = 1'b0;
    st4 = cyc;
    active4 = 1'b1;
    q4.push_back(model(g, e, cyc + 40));
    n = 0;
    if (restart_at > 0) begin
      tick(restart_at - 1 - n);
      if4.expected_code = ~e;
      if4.start = 1'b1;
      tick(1);
      if4.start = 1'b0;
      if4.expected_code = e;
      n = restart_at;
    end
    if (abort_at > 0) begin
      tick(abort_at - 1 - n);
      if4.abort = 1'b1;
      tick(1);
      if4.abort = 1'b0;
      void'(q4.pop_back());
      active4 = 1'b0;
      chk("abort_busy", int'(if4.busy), 0);
      chk("abort_stim", int'(if4.stim), 0);
      chk("abort_done", int'(if4.done), 0);
      chk("abort_hold", int'(if4.table_code), int'(last4));
      tick(5);
    end else begin
      drain4();
      last4 = model(g, e, 0).code;
      chk("hold4", int'(if4.table_code), int'(last4));
    end
  endtask

  task automatic sweep0(input logic [7:0] g, input logic [7:0] e);
    gate0 = g;
    if0.expected_code = e;
    if0.start = 1'b1;
    tick(1);
    if0.start = 1'b0;
    st0 = cyc;
    active0 = 1'b1;
    q0.push_back(model(g, e, cyc + 8));
    drain0();
  endtask

  initial begin
    logic [7:0] g, e;
    if4.start = 1'b0; if4.abort = 1'b0; if4.expected_code = '0;
    if0.start = 1'b0; if0.abort = 1'b0; if0.expected_code = '0;
    tick(3);
    chk("rst_busy", int'(if4.busy), 0);
    chk("rst_stim", int'(if4.stim), 0);
    chk("rst_done", int'(if4.done), 0);
    chk("rst_code", int'(if4.table_code), 0);
    chk("rst_match", int'(if4.match), 0);
    chk("rst_mask", int'(if4.mismatch_mask), 0);
    rst_n = 1'b1;
    tick(2);

    sweep4(8'hB4, 8'hB4, 0, 0);
    sweep4(8'hB4, 8'hB5, 0, 0);

    // Constant-1 device then constant-0 device, second start in the done cycle.
    gate0 = 8'hFF;
    if0.expected_code = 8'hFF;
    if0.start = 1'b1;
    tick(1);
    if0.start = 1'b0;
    st0 = cyc;
    active0 = 1'b1;
    q0.push_back(model(8'hFF, 8'hFF, cyc + 8));
    tick(8);
    chk("b2b_done_seen", int'(if0.done), 1);
    gate0 = 8'h00;
    if0.expected_code = 8'h00;
    if0.start = 1'b1;
    tick(1);
    if0.start = 1'b0;
    st0 = cyc;
    q0.push_back(model(8'h00, 8'h00, cyc + 8));
    drain0();

    // start with abort in IDLE must not launch a sweep.
    if4.start = 1'b1;
    if4.abort = 1'b1;
    tick(1);
    if4.start = 1'b0;
    if4.abort = 1'b0;
    chk("start_abort_idle", int'(if4.busy), 0);
    tick(3);

    sweep4(8'h3C, 8'h3C, 17, 0);
    sweep4(8'h96, 8'h96, 0, 10);

    for (int i = 0; i < 8; i++) begin
      g = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? g : 8'($urandom);
      if ($urandom_range(0, 1) == 1) sweep4(g, e, 0, 0);
      else sweep0(g, e);
    end

    // Asynchronous reset between edges in the middle of a sweep.
    gate4 = 8'hE8;
    if4.expected_code = 8'hE8;
    if4.start = 1'b1;
    tick(1);
    if4.start = 1'b0;
    st4 = cyc;
    active4 = 1'b1;
    q4.push_back(model(8'hE8, 8'hE8, cyc + 40));
    tick(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(if4.busy), 0);
    chk("arst_stim", int'(if4.stim), 0);
    chk("arst_done", int'(if4.done), 0);
    chk("arst_code", int'(if4.table_code), 0);
    chk("arst_match", int'(if4.match), 0);
    chk("arst_mask", int'(if4.mismatch_mask), 0);
    chk("arst_code0", int'(if0.table_code), 0);
    void'(q4.pop_back());
    active4 = 1'b0;
    last4 = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    sweep4(8'h6A, 8'h6B, 0, 0);
    sweep0(8'h81, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
